// File: rtl/gol_pkg.sv
// Shared types and Game of Life rule constants for the row sequencer.
package gol_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    COMMIT,
    DONE
  } state_t;

  localparam logic [3:0] BIRTH       = 4'd3;
  localparam logic [3:0] SURVIVE_MIN = 4'd2;
  localparam logic [3:0] SURVIVE_MAX = 4'd3;

endpackage

// File: rtl/gol_row_next.sv
// Combinational next-generation row: B3/S23 rule with column wrap-around.
module gol_row_next
  import gol_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_row_a,
  input  logic [WIDTH-1:0] i_row,
  input  logic [WIDTH-1:0] i_row_b,
  output logic [WIDTH-1:0] o_next
);

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    o_next = '0;
    for (int i = 0; i < WIDTH; i++) begin : g_col
      int         l;
      int         r;
      logic [3:0] cnt;
      l   = (i + WIDTH - 1) % WIDTH;
      r   = (i + 1) % WIDTH;
      cnt = 4'(i_row_a[l]) + 4'(i_row_a[i]) + 4'(i_row_a[r])
          + 4'(i_row[l])                    + 4'(i_row[r])
          + 4'(i_row_b[l]) + 4'(i_row_b[i]) + 4'(i_row_b[r]);
      if (i_row[i]) o_next[i] = (cnt >= SURVIVE_MIN) && (cnt <= SURVIVE_MAX);
      else          o_next[i] = (cnt == BIRTH);
    end
  end

endmodule

// File: rtl/gol_sequencer.sv
// Game of Life controller: loads a board into the row register file and
// steps it through COMPUTE (read all rows) / COMMIT (write all rows) phases.
module gol_sequencer
  import gol_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int GENBITS = 16
) (
  input  logic               ph1,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               start,
  input  logic [GENBITS-1:0] gens,
  output logic               busy,
  output logic               done,
  output logic [GENBITS-1:0] gen_count,
  output logic [REGBITS-1:0] ra,
  input  logic [WIDTH-1:0]   row_a,
  input  logic [WIDTH-1:0]   row,
  input  logic [WIDTH-1:0]   row_b,
  output logic               regwrite,
  output logic [REGBITS-1:0] wa,
  output logic [WIDTH-1:0]   wd
);

  localparam int                 N        = 2 ** REGBITS;
  localparam logic [REGBITS-1:0] LAST_ROW = {REGBITS{1'b1}};

  state_t             r_state;
  logic [REGBITS-1:0] r_row;
  logic [REGBITS-1:0] r_load_ptr;
  logic [GENBITS-1:0] r_remaining;
  logic [GENBITS-1:0] r_gen_count;
  logic               r_load_ready;
  logic [WIDTH-1:0]   r_nxt [N];
  logic [WIDTH-1:0]   w_next_row;
  logic               w_load_fire;

  // load_ready is only ever high in IDLE, so a fired beat implies IDLE.
  assign w_load_fire = load_valid & r_load_ready;

  gol_row_next #(.WIDTH(WIDTH)) u_row_next (
    .i_row_a (row_a),
    .i_row   (row),
    .i_row_b (row_b),
    .o_next  (w_next_row)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_row        <= '0;
      r_load_ptr   <= '0;
      r_remaining  <= '0;
      r_gen_count  <= '0;
      r_load_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_load_ready <= !start;
          if (w_load_fire) r_load_ptr <= r_load_ptr + 1'b1;
          if (start) begin
            r_gen_count <= '0;
            if (gens != '0) begin
              r_remaining <= gens;
              r_load_ptr  <= '0;
              r_row       <= '0;
              r_state     <= COMPUTE;
            end else begin
              r_state     <= DONE;
            end
          end
        end
        COMPUTE: begin
          r_row <= r_row + 1'b1;
          if (r_row == LAST_ROW) r_state <= COMMIT;
        end
        COMMIT: begin
          r_row <= r_row + 1'b1;
          if (r_row == LAST_ROW) begin
            r_gen_count <= r_gen_count + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            r_state     <= (r_remaining == GENBITS'(1)) ? DONE : COMPUTE;
          end
        end
        DONE: begin
          r_state      <= IDLE;
          r_load_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: the nxt buffer has no reset; COMPUTE always rewrites every entry before COMMIT reads it.
  always_ff @(posedge ph1) begin
    if (r_state == COMPUTE) r_nxt[r_row] <= w_next_row;
  end

  always_comb begin
    regwrite = 1'b0;
    wa       = '0;
    wd       = '0;
    if (r_state == COMMIT) begin
      regwrite = 1'b1;
      wa       = r_row;
      wd       = r_nxt[r_row];
    end else if (w_load_fire) begin
      regwrite = 1'b1;
      wa       = r_load_ptr;
      wd       = load_data;
    end
  end

  assign load_ready = r_load_ready;
  assign busy       = (r_state == COMPUTE) || (r_state == COMMIT);
  assign done       = (r_state == DONE);
  assign gen_count  = r_gen_count;
  assign ra         = r_row;

endmodule
